// File: rtl/crash_pkg.sv
// Shared types, widths and helpers for the crash detector.
// The axis width lives here because MAG_W and abs_u are derived from it.
package crash_pkg;

    localparam int DATA_W = 12;
    localparam int MAG_W  = DATA_W + 2;

    typedef enum logic [1:0] {
        SAFE  = 2'd0,
        COUNT = 2'd1,
        CRASH = 2'd2
    } state_t;

    // abs of the most negative value is 2^(DATA_W-1), still representable unsigned
    function automatic logic [DATA_W-1:0] abs_u(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
    endfunction

endpackage

// File: rtl/crash_watchdog.sv
// Saturating idle counter: fault is high while no sample has been accepted
// for TIMEOUT_CYC cycles; an accept restarts the count.
module crash_watchdog #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic accept,
    output logic fault
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

    logic [CW-1:0] idle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idle <= '0;
        else if (accept)
            idle <= '0;
        else if (idle != LIMIT)
            idle <= idle + 1'b1;
    end

    assign fault = (idle == LIMIT);

endmodule

// File: rtl/crash_detector.sv
// Accelerometer crash qualifier: L1 magnitude per sample, HOLD consecutive
// over-threshold samples latch crash_o. Optional peak tracking: CRASH_PEAK_EN.
module crash_detector
    import crash_pkg::*;
#(
    parameter int THRESH      = 1536,
    parameter int HOLD        = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_x,
    input  logic [DATA_W-1:0] s_y,
    input  logic [DATA_W-1:0] s_z,
    input  logic              clear_i,
    output logic              crash_o,
    output logic              sensor_fault_o,
    output logic [MAG_W-1:0]  mag_o
`ifdef CRASH_PEAK_EN
    ,
    output logic [MAG_W-1:0]  peak_o
`endif
);

    state_t            state, state_next;
    logic [3:0]        count, count_next;
    logic              accept, mag_v, q;
    logic [DATA_W-1:0] ax, ay, az;
    logic [MAG_W-1:0]  mag_sum;

    assign accept = s_valid && s_ready;

    always_comb begin
        ax      = abs_u(s_x);
        ay      = abs_u(s_y);
        az      = abs_u(s_z);
        mag_sum = MAG_W'(ax) + MAG_W'(ay) + MAG_W'(az);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_ready <= 1'b0;
            mag_v   <= 1'b0;
            mag_o   <= '0;
        end else begin
            s_ready <= 1'b1;
            mag_v   <= accept;
            if (accept)
                mag_o <= mag_sum;
        end
    end

    assign q = (mag_o > MAG_W'(THRESH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SAFE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            SAFE: begin
                if (mag_v && q) begin
                    if (HOLD == 1) begin
                        state_next = CRASH;
                        count_next = '0;
                    end else begin
                        state_next = COUNT;
                        count_next = 4'd1;
                    end
                end
            end
            COUNT: begin
                if (mag_v) begin
                    if (!q) begin
                        state_next = SAFE;
                        count_next = '0;
                    end else if (count + 4'd1 == 4'(HOLD)) begin
                        state_next = CRASH;
                        count_next = '0;
                    end else begin
                        count_next = count + 4'd1;
                    end
                end
            end
            CRASH: begin
                // clear outranks any sample arriving in the same cycle
                count_next = '0;
                if (clear_i)
                    state_next = SAFE;
            end
            default: begin
                state_next = SAFE;
                count_next = '0;
            end
        endcase
    end

    always_comb begin
        crash_o = (state == CRASH);
    end

`ifdef CRASH_PEAK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            peak_o <= '0;
        else if (state == CRASH && clear_i)
            peak_o <= '0;
        else if (mag_v && q && state == SAFE)
            peak_o <= mag_o;
        else if (mag_v && q && state == COUNT && mag_o > peak_o)
            peak_o <= mag_o;
    end
`endif

    crash_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .accept (accept),
        .fault  (sensor_fault_o)
    );

endmodule

// File: tb/tb_crash_detector.sv
// Directed bench for crash_detector: vector table plus hand-written
// sequences for back-to-back, watchdog and asynchronous reset.
module tb_crash_detector;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] s_x, s_y, s_z;
    logic        clear_i;
    logic        crash_o;
    logic        sensor_fault_o;
    logic [13:0] mag_o;
`ifdef CRASH_PEAK_EN
    logic [13:0] peak_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    crash_detector #(
        .THRESH      (1536),
        .HOLD        (4),
        .TIMEOUT_CYC (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_x            (s_x),
        .s_y            (s_y),
        .s_z            (s_z),
        .clear_i        (clear_i),
        .crash_o        (crash_o),
        .sensor_fault_o (sensor_fault_o),
        .mag_o          (mag_o)
`ifdef CRASH_PEAK_EN
        ,
        .peak_o         (peak_o)
`endif
    );

    typedef struct {
        int   x;
        int   y;
        int   z;
        logic clr;
        int   mag;
        logic crash;
        int   peak;
    } vec_t;

    vec_t vecs[28];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // one accepted sample, clear_i driven in the mag_v cycle, returns at the
    // negedge after the FSM has evaluated that sample
    task automatic apply(input int x, input int y, input int z, input logic clr);
        @(negedge clk);
        s_valid = 1'b1;
        s_x = 12'(x);
        s_y = 12'(y);
        s_z = 12'(z);
        @(negedge clk);
        s_valid = 1'b0;
        clear_i = clr;
        @(negedge clk);
        clear_i = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{600, 600, 600, 1'b0, 1800, 1'b0, 1800};
        vecs[1]  = '{600, 600, 600, 1'b0, 1800, 1'b0, 1800};
        vecs[2]  = '{600, 600, 600, 1'b0, 1800, 1'b0, 1800};
        vecs[3]  = '{600, 600, 600, 1'b0, 1800, 1'b1, 1800};
        vecs[4]  = '{600, 600, 600, 1'b1, 1800, 1'b0, 0};
        vecs[5]  = '{600, 600, 600, 1'b0, 1800, 1'b0, 1800};
        vecs[6]  = '{600, 600, 600, 1'b0, 1800, 1'b0, 1800};
        vecs[7]  = '{600, 600, 600, 1'b0, 1800, 1'b0, 1800};
        vecs[8]  = '{600, 600, 600, 1'b0, 1800, 1'b1, 1800};
        vecs[9]  = '{0, 0, 0, 1'b1, 0, 1'b0, 0};
        vecs[10] = '{600, 600, 600, 1'b1, 1800, 1'b0, 1800};
        vecs[11] = '{600, 600, 600, 1'b0, 1800, 1'b0, 1800};
        vecs[12] = '{600, 600, 600, 1'b1, 1800, 1'b0, 1800};
        vecs[13] = '{600, 600, 600, 1'b0, 1800, 1'b1, 1800};
        vecs[14] = '{0, 0, 0, 1'b1, 0, 1'b0, 0};
        vecs[15] = '{600, 600, 600, 1'b0, 1800, 1'b0, 1800};
        vecs[16] = '{600, 600, 600, 1'b0, 1800, 1'b0, 1800};
        vecs[17] = '{600, 600, 600, 1'b0, 1800, 1'b0, 1800};
        vecs[18] = '{512, 512, 512, 1'b0, 1536, 1'b0, 1800};
        vecs[19] = '{600, 600, 600, 1'b0, 1800, 1'b0, 1800};
        vecs[20] = '{600, 600, 600, 1'b0, 1800, 1'b0, 1800};
        vecs[21] = '{600, 600, 600, 1'b0, 1800, 1'b0, 1800};
        vecs[22] = '{512, 512, 512, 1'b0, 1536, 1'b0, 1800};
        vecs[23] = '{-600, 700, -600, 1'b0, 1900, 1'b0, 1900};
        vecs[24] = '{2047, -2048, 0, 1'b0, 4095, 1'b0, 4095};
        vecs[25] = '{-600, 600, -600, 1'b0, 1800, 1'b0, 4095};
        vecs[26] = '{-2048, -2048, -2048, 1'b0, 6144, 1'b1, 6144};
        vecs[27] = '{0, 0, 0, 1'b1, 0, 1'b0, 0};

        reset   = 1'b1;
        s_valid = 1'b0;
        s_x = '0;
        s_y = '0;
        s_z = '0;
        clear_i = 1'b0;

        #2;
        chk("rst crash", int'(crash_o), 0);
        chk("rst fault", int'(sensor_fault_o), 0);
        chk("rst mag", int'(mag_o), 0);
        chk("rst ready", int'(s_ready), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready after release", int'(s_ready), 1);

        for (int i = 0; i < 28; i++) begin
            apply(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].clr);
            chk($sformatf("vec%0d mag", i), int'(mag_o), vecs[i].mag);
            chk($sformatf("vec%0d crash", i), int'(crash_o), int'(vecs[i].crash));
`ifdef CRASH_PEAK_EN
            chk($sformatf("vec%0d peak", i), int'(peak_o), vecs[i].peak);
`endif
        end

        // back-to-back samples, s_valid held high for 4 cycles
        @(negedge clk);
        s_valid = 1'b1;
        s_x = 12'd600;
        s_y = 12'd600;
        s_z = 12'd600;
        repeat (4) @(negedge clk);
        s_valid = 1'b0;
        chk("b2b crash before", int'(crash_o), 0);
        chk("b2b mag", int'(mag_o), 1800);
        @(negedge clk);
        chk("b2b crash", int'(crash_o), 1);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("b2b clear", int'(crash_o), 0);

        // watchdog: fault after 10 idle edges, saturates, drops on accept
        @(negedge clk);
        s_valid = 1'b1;
        s_x = '0;
        s_y = '0;
        s_z = '0;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("wd idle 9", int'(sensor_fault_o), 0);
        @(posedge clk);
        #1;
        chk("wd idle 10", int'(sensor_fault_o), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("wd saturated", int'(sensor_fault_o), 1);
        @(negedge clk);
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        chk("wd cleared", int'(sensor_fault_o), 0);

        // async reset mid-COUNT loses the partial count
        for (int i = 0; i < 3; i++) begin
            apply(600, 600, 600, 1'b0);
            chk($sformatf("pre-rst s%0d crash", i), int'(crash_o), 0);
        end
        #2;
        reset = 1'b1;
        #1;
        chk("async rst mag", int'(mag_o), 0);
        chk("async rst ready", int'(s_ready), 0);
        chk("async rst crash", int'(crash_o), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            apply(600, 600, 600, 1'b0);
            chk($sformatf("post-rst s%0d crash", i), int'(crash_o), 0);
        end
        apply(600, 600, 600, 1'b0);
        chk("post-rst s3 crash", int'(crash_o), 1);

        // async reset mid-CRASH
        #2;
        reset = 1'b1;
        #1;
        chk("async rst in crash", int'(crash_o), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
